store_rmw_ctrl: RTL and testbench
=================================

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 The module SHALL have parameter READ_LATENCY, default 1, legal range 1..4, giving cycles from a mem_rd_en pulse to valid mem_rdata.
REQ-002 The module SHALL have clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have req, input, 1, store request.
REQ-005 The module SHALL have ready, output, 1, controller idle and able to accept.
REQ-006 The module SHALL have addr, input, 32, store byte address.
REQ-007 The module SHALL have data, input, 32, store source data, right-aligned.
REQ-008 The module SHALL have funct3, input, 3, store size: 000 byte, 001 half, 010 word.
REQ-009 The module SHALL have mem_addr, output, 32, word-aligned memory address.
REQ-010 The module SHALL have mem_rd_en, output, 1, one-cycle read strobe.
REQ-011 The module SHALL have mem_rdata, input, 32, old word read from memory.
REQ-012 The module SHALL have mem_wr_en, output, 1, one-cycle write strobe.
REQ-013 The module SHALL have mem_wdata, output, 32, merged word to write.
REQ-014 The module SHALL have done, output, 1, one-cycle completion pulse.
REQ-015 The module SHALL have err, output, 1, one-cycle error pulse, coincident with done.

Function
REQ-016 The controller SHALL be an FSM with states IDLE, READ, WAIT, WRITE, FINISH.
REQ-017 ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req=1 and ready=1, and addr, data and funct3 are registered at that edge.
REQ-018 Input changes after acceptance SHALL have no effect on the operation in progress.
REQ-019 req while ready=0 SHALL be ignored, not queued.
REQ-020 mem_addr SHALL equal {addr_q[31:2],2'b00} in every non-IDLE state, and 0 in IDLE.
REQ-021 Byte store (000): IDLE->READ->WAIT->WRITE->IDLE; mem_rd_en=1 for the single READ cycle.
REQ-022 WAIT SHALL last exactly READ_LATENCY cycles, counted by a down-counter, and mem_rdata SHALL be captured on the last WAIT edge.
REQ-023 Byte merge SHALL replace lane addr_q[1:0] (lane 0 = bits 7:0) of the captured old word with data_q[7:0] and keep the other lanes.
REQ-024 Half store (001) with addr_q[0]=0 SHALL follow the byte path and replace bits 15:0 when addr_q[1]=0, or bits 31:16 when addr_q[1]=1.
REQ-025 Word store (010) with addr_q[1:0]=00 SHALL go IDLE->WRITE->IDLE with mem_wdata=data_q and no read.
REQ-026 In WRITE, mem_wr_en=1 and done=1 for exactly one cycle.
REQ-027 Sub-word latency SHALL be mem_wr_en at accept edge+2+READ_LATENCY cycles, with ready high again one cycle later.
REQ-028 Word latency SHALL be mem_wr_en in the cycle after accept.
REQ-029 Funct3 values 011..111 SHALL go IDLE->FINISH->IDLE with done=1, err=1 and no memory strobes.
REQ-030 mem_wdata SHALL be 0 outside WRITE.
REQ-031 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.

Reset
REQ-032 While reset_n=0, the FSM SHALL be in IDLE; ready=1; mem_rd_en, mem_wr_en, done and err SHALL be 0; mem_addr, mem_wdata and all captured registers SHALL be 0.
REQ-033 Assertion of reset_n mid-operation SHALL abort immediately and asynchronously with no write issued; the aborted store is lost.

Configuration
REQ-034 With STORE_MISALIGN_TRAP_EN defined, a misaligned store (half with addr[0]=1, or word with addr[1:0]!=00) SHALL take the FINISH path with err=1 and no memory access.
REQ-035 Without STORE_MISALIGN_TRAP_EN, misaligned addresses SHALL be forced aligned (half ignores addr[0], word ignores addr[1:0]) and the store SHALL proceed with err never asserted for misalignment.

Verification
REQ-036 Byte store, READ_LATENCY=1: addr=0x103, data=0xAB, old=0x11223344 -> mem_rd_en 1 cycle after accept, mem_wr_en 3 cycles after accept, mem_addr=0x100, mem_wdata=0xAB223344, done=1, err=0.
REQ-037 Half store, READ_LATENCY=3: addr=0x202, data=0xBEEF, old=0xCAFE1234 -> wr 5 cycles after accept, mem_wdata=0xBEEF1234.
REQ-038 Word store: addr=0x40, data=0xDEADBEEF -> no mem_rd_en, mem_wr_en 1 cycle after accept, mem_wdata=0xDEADBEEF.
REQ-039 Case A, funct3=011: done=1, err=1, no strobes. Case B, STORE_MISALIGN_TRAP_EN defined, half store at addr=0x201: done=1, err=1, no strobes. Case C, macro undefined, half store at addr=0x201: write to lane 0 proceeds with err=0.
REQ-040 Assert reset_n=0 in WAIT of a byte store -> outputs take reset values immediately, no mem_wr_en afterwards, ready=1 after release; req held during busy -> only one store is performed.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// Sub-word store controller: read-modify-write of a 32-bit memory word for byte/half
// stores, direct write for word stores. Optional macro STORE_MISALIGN_TRAP_EN traps misaligned stores.
module store_rmw_ctrl #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    output logic        ready,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [2:0]  funct3,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic [31:0] mem_wdata,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cnt_q, cnt_d;

    logic        misaligned;
    logic        bad_op;

    // Replace the addressed lane(s) of the old word; half stores select by addr[1] only.
    function automatic logic [31:0] merge_store(
        input logic [31:0] old_word,
        input logic [31:0] new_data,
        input logic [1:0]  lane,
        input logic [2:0]  size
    );
        logic [31:0] w;
        w = old_word;
        case (size)
            F3_BYTE: begin
                case (lane)
                    2'd0:    w[7:0]   = new_data[7:0];
                    2'd1:    w[15:8]  = new_data[7:0];
                    2'd2:    w[23:16] = new_data[7:0];
                    default: w[31:24] = new_data[7:0];
                endcase
            end
            F3_HALF: begin
                if (lane[1]) w[31:16] = new_data[15:0];
                else         w[15:0]  = new_data[15:0];
            end
            default: w = new_data;
        endcase
        return w;
    endfunction

    always_comb begin
`ifdef STORE_MISALIGN_TRAP_EN
        misaligned = ((funct3 == F3_HALF) && addr[0]) ||
                     ((funct3 == F3_WORD) && (addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        bad_op = (funct3 > F3_WORD) || misaligned;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            funct3_q <= 3'd0;
            rdata_q  <= 32'd0;
            cnt_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    data_d   = data;
                    funct3_d = funct3;
                    if (bad_op)                 state_d = S_FINISH;
                    else if (funct3 == F3_WORD) state_d = S_WRITE;
                    else                        state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            // Old word is sampled on the final WAIT edge, READ_LATENCY cycles after the strobe.
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WRITE:  state_d = S_IDLE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == S_IDLE);
        mem_addr  = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
        mem_rd_en = (state_q == S_READ);
        mem_wr_en = (state_q == S_WRITE);
        mem_wdata = (state_q == S_WRITE) ? merge_store(rdata_q, data_q, addr_q[1:0], funct3_q)
                                         : 32'd0;
        done      = (state_q == S_WRITE) || (state_q == S_FINISH);
        err       = (state_q == S_FINISH);
    end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (READ_LATENCY 1 and 3) share stimulus and are
// checked every cycle against a transaction-level model, plus literal per-store expectations.
module tb_store_rmw_ctrl;

    localparam logic [31:0] JUNK = 32'h5A5A5A5A;

    logic        clock;
    logic        reset_n;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;

    logic        ready_w   [2];
    logic [31:0] maddr_w   [2];
    logic        rd_w      [2];
    logic [31:0] rdata_w   [2];
    logic        wr_w      [2];
    logic [31:0] wdata_w   [2];
    logic        done_w    [2];
    logic        err_w     [2];

    store_rmw_ctrl #(.READ_LATENCY(1)) dut_rl1 (
        .clock(clock), .reset_n(reset_n), .req(req), .ready(ready_w[0]),
        .addr(addr), .data(data), .funct3(funct3),
        .mem_addr(maddr_w[0]), .mem_rd_en(rd_w[0]), .mem_rdata(rdata_w[0]),
        .mem_wr_en(wr_w[0]), .mem_wdata(wdata_w[0]), .done(done_w[0]), .err(err_w[0])
    );

    store_rmw_ctrl #(.READ_LATENCY(3)) dut_rl3 (
        .clock(clock), .reset_n(reset_n), .req(req), .ready(ready_w[1]),
        .addr(addr), .data(data), .funct3(funct3),
        .mem_addr(maddr_w[1]), .mem_rd_en(rd_w[1]), .mem_rdata(rdata_w[1]),
        .mem_wr_en(wr_w[1]), .mem_wdata(wdata_w[1]), .done(done_w[1]), .err(err_w[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memories feeding the DUTs, their read pipelines, and the model's own memory image.
    logic [31:0] mem   [2][0:1023];
    logic [31:0] m_img [2][0:1023];
    logic [31:0] pipe  [2][0:2];
    logic        mem_init = 1'b0;

    assign rdata_w[0] = pipe[0][0];
    assign rdata_w[1] = pipe[1][2];

    // Model state: one outstanding store per instance, k = cycles since acceptance.
    logic        m_busy  [2];
    int          m_k     [2];
    int          m_dur   [2];
    logic [1:0]  m_kind  [2];   // 0 sub-word RMW, 1 word, 2 error
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];

    function automatic int rl_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int j);
        case (j)
            64:      return 32'h11223344;
            128:     return 32'hCAFE1234;
            default: return (32'(j) * 32'h00010001) ^ 32'hA5000000;
        endcase
    endfunction

    function automatic logic [1:0] classify(input logic [31:0] a, input logic [2:0] f3);
        if (f3 > 3'd2) return 2'd2;
`ifdef STORE_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00)) return 2'd2;
`endif
        return (f3 == 3'd2) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, a, d, input logic [2:0] f3);
        int sh;
        if (f3 == 3'd0) begin
            sh = 8 * int'(a[1:0]);
            return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end
        if (f3 == 3'd1) begin
            sh = 16 * int'(a[1]);
            return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] <= 1'b0;
                m_k[i]    <= 0;
                for (int s = 0; s < 3; s++) pipe[i][s] <= JUNK;
            end
            if (!mem_init) begin
                for (int j = 0; j < 1024; j++) begin
                    for (int i = 0; i < 2; i++) begin
                        mem[i][10'(j)]   <= init_word(j);
                        m_img[i][10'(j)] <= init_word(j);
                    end
                end
                mem_init <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_w[i]) mem[i][maddr_w[i][11:2]] <= wdata_w[i];
                pipe[i][0] <= rd_w[i] ? mem[i][maddr_w[i][11:2]] : JUNK;
                pipe[i][1] <= pipe[i][0];
                pipe[i][2] <= pipe[i][1];
                if (!m_busy[i]) begin
                    if (req) begin
                        m_busy[i]  <= 1'b1;
                        m_k[i]     <= 1;
                        m_kind[i]  <= classify(addr, funct3);
                        m_dur[i]   <= (classify(addr, funct3) == 2'd0) ? 2 + rl_of(i) : 1;
                        m_addr[i]  <= {addr[31:2], 2'b00};
                        m_wdata[i] <= ref_merge(m_img[i][addr[11:2]], addr, data, funct3);
                    end
                end else if (m_k[i] == m_dur[i]) begin
                    m_busy[i] <= 1'b0;
                    if (m_kind[i] != 2'd2) m_img[i][m_addr[i][11:2]] <= m_wdata[i];
                end else begin
                    m_k[i] <= m_k[i] + 1;
                end
            end
        end
    end

    // Literal expectations for the store currently being issued.
    int          arm_seq = 0;
    int          lit_lat [2];
    logic [31:0] lit_wdata;
    logic        lit_err;
    int          lit_rd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s rl%0d: got %h, expected %h at %0t", nm, rl_of(i), act, exp, $time);
    endtask

    initial begin
        int   seen;
        logic armed [2];
        int   cnt [2];
        int   rdc [2];
        logic last, e_ready, e_rd, e_wr, e_done, e_err;
        logic [31:0] e_addr, e_wd;
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b0; cnt[i] = 0; rdc[i] = 0;
        end
        forever begin
            @(negedge clock);
            if (arm_seq != seen) begin
                seen = arm_seq;
                for (int i = 0; i < 2; i++) begin
                    armed[i] = 1'b1; cnt[i] = 0; rdc[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (!reset_n || !m_busy[i]) begin
                    e_ready = 1'b1; e_addr = 32'd0; e_rd = 1'b0; e_wr = 1'b0;
                    e_wd = 32'd0; e_done = 1'b0; e_err = 1'b0;
                end else begin
                    last    = (m_k[i] == m_dur[i]);
                    e_ready = 1'b0;
                    e_addr  = m_addr[i];
                    e_rd    = (m_kind[i] == 2'd0) && (m_k[i] == 1);
                    e_wr    = last && (m_kind[i] != 2'd2);
                    e_done  = last;
                    e_err   = last && (m_kind[i] == 2'd2);
                    e_wd    = e_wr ? m_wdata[i] : 32'd0;
                end
                chk("ready",     i, 32'(ready_w[i]), 32'(e_ready));
                chk("mem_addr",  i, maddr_w[i],      e_addr);
                chk("mem_rd_en", i, 32'(rd_w[i]),    32'(e_rd));
                chk("mem_wr_en", i, 32'(wr_w[i]),    32'(e_wr));
                chk("mem_wdata", i, wdata_w[i],      e_wd);
                chk("done",      i, 32'(done_w[i]),  32'(e_done));
                chk("err",       i, 32'(err_w[i]),   32'(e_err));

                if (armed[i]) begin
                    cnt[i]++;
                    if (rd_w[i]) rdc[i]++;
                    if (done_w[i]) begin
                        chk("lit_latency", i, 32'(cnt[i] - 1), 32'(lit_lat[i]));
                        chk("lit_wdata",   i, wdata_w[i],      lit_wdata);
                        chk("lit_err",     i, 32'(err_w[i]),   32'(lit_err));
                        chk("lit_rd_cnt",  i, 32'(rdc[i]),     32'(lit_rd));
                        armed[i] = 1'b0;
                    end else if (cnt[i] > 9) begin
                        chk("done_timeout", i, 32'd0, 32'd1);
                        armed[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                         input int hold, input logic [31:0] w, input logic e);
        logic sub;
        sub = !e && (f3 != 3'd2);
        @(posedge clock); #2;
        lit_wdata  = w;
        lit_err    = e;
        lit_rd     = sub ? 1 : 0;
        lit_lat[0] = sub ? 3 : 1;
        lit_lat[1] = sub ? 5 : 1;
        arm_seq++;
        addr = a; data = d; funct3 = f3; req = 1'b1;
        @(posedge clock); #2;
        if (hold > 0) begin
            addr = 32'h100; data = 32'hFF; funct3 = 3'd2;
            repeat (hold) @(posedge clock);
            #2;
        end
        req = 1'b0;
        repeat (8) @(posedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 1'b0;
        addr    = 32'd0;
        data    = 32'd0;
        funct3  = 3'd0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clock);

        issue(32'h103, 32'hFFFFFFAB, 3'b000, 0, 32'hAB223344, 1'b0);
        issue(32'h202, 32'h1234BEEF, 3'b001, 0, 32'hBEEF1234, 1'b0);
        issue(32'h040, 32'hDEADBEEF, 3'b010, 0, 32'hDEADBEEF, 1'b0);
        issue(32'h100, 32'h12345678, 3'b011, 0, 32'h00000000, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
        issue(32'h201, 32'h00005566, 3'b001, 0, 32'h00000000, 1'b1);
`else
        issue(32'h201, 32'h00005566, 3'b001, 0, 32'hBEEF5566, 1'b0);
`endif
        issue(32'h101, 32'h00000077, 3'b000, 2, 32'hAB227744, 1'b0);
        issue(32'h102, 32'h12349999, 3'b001, 0, 32'h99997744, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
        issue(32'h043, 32'h01020304, 3'b010, 0, 32'h00000000, 1'b1);
`else
        issue(32'h043, 32'h01020304, 3'b010, 0, 32'h01020304, 1'b0);
`endif
        issue(32'h200, 32'hFFFFFFFF, 3'b111, 0, 32'h00000000, 1'b1);

        // Byte store aborted by reset while both instances sit in WAIT.
        @(posedge clock); #2;
        addr = 32'h100; data = 32'hEE; funct3 = 3'b000; req = 1'b1;
        @(posedge clock); #2;
        req = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (8) @(posedge clock);

        issue(32'h100, 32'h0000005A, 3'b000, 0, 32'h9999775A, 1'b0);

        repeat (4) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
